sobel_stream: RTL and testbench

SOBEL_STREAM -- requirements
Module: sobel_stream

---
 rtl/sobel_stream.sv | 151 +++++++++++++++
 tb/tb_sobel_stream.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge detector with valid/ready handshake on both sides.
// Optional magnitude output enabled by defining SOBEL_MAG_OUT_EN.
module sobel_stream #(
    parameter int PIX_W = 8,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PIX_W-1:0]   in_pix,
    input  logic               in_sof,
    input  logic [PIX_W+3:0]   thresh,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_edge
`ifdef SOBEL_MAG_OUT_EN
    ,
    output logic [PIX_W-1:0]   out_mag
`endif
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int SW = PIX_W + 3;
    localparam int MW = PIX_W + 4;

    function automatic logic signed [SW-1:0] ext_f(input logic [PIX_W-1:0] p);
        return signed'({3'b000, p});
    endfunction

    function automatic logic [SW-1:0] abs_f(input logic signed [SW-1:0] v);
        if (v[SW-1]) begin
            return SW'(-v);
        end else begin
            return v;
        end
    endfunction

    logic                    advance_s, accept_s, produce_s;
    logic [CW-1:0]           col_q, col_d, pos_col_s;
    logic [RW-1:0]           row_q, row_d, pos_row_s;
    logic [PIX_W-1:0]        lb0_q [IMG_W];
    logic [PIX_W-1:0]        lb1_q [IMG_W];
    logic [PIX_W-1:0]        top_s, mid_s, bot_s;
    logic [PIX_W-1:0]        t0_q, t1_q, m0_q, m1_q, b0_q, b1_q;
    logic signed [SW-1:0]    gx_d, gy_d, gx_q, gy_q;
    logic                    s1_valid_q;
    logic [MW-1:0]           sum_s;
    logic                    out_valid_q, out_edge_q;

    // Handshake, raster position tracking and stage-1 gradient computation.
    always_comb begin
        advance_s = !out_valid_q || out_ready;
        accept_s  = in_valid && advance_s;
        pos_col_s = in_sof ? {CW{1'b0}} : col_q;
        pos_row_s = in_sof ? {RW{1'b0}} : row_q;
        col_d     = col_q;
        row_d     = row_q;
        if (accept_s) begin
            if (pos_col_s == CW'(IMG_W - 1)) begin
                col_d = {CW{1'b0}};
                row_d = (pos_row_s == RW'(IMG_H - 1)) ? {RW{1'b0}} : pos_row_s + RW'(1);
            end else begin
                col_d = pos_col_s + CW'(1);
                row_d = pos_row_s;
            end
        end else begin
            col_d = col_q;
            row_d = row_q;
        end
        produce_s = accept_s && (pos_row_s >= RW'(2)) && (pos_col_s >= CW'(2));
        // The incoming column forms the right edge of the window; t/m/b hold c-2 and c-1.
        top_s = lb1_q[pos_col_s];
        mid_s = lb0_q[pos_col_s];
        bot_s = in_pix;
        gx_d  = (ext_f(top_s) - ext_f(t0_q)) + ((ext_f(mid_s) - ext_f(m0_q)) <<< 1)
              + (ext_f(bot_s) - ext_f(b0_q));
        gy_d  = (ext_f(t0_q) - ext_f(b0_q)) + ((ext_f(t1_q) - ext_f(b1_q)) <<< 1)
              + (ext_f(top_s) - ext_f(bot_s));
        sum_s = {1'b0, abs_f(gx_q)} + {1'b0, abs_f(gy_q)};
    end

    // Line buffers: previous two lines, no reset needed.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            lb0_q[pos_col_s] <= in_pix;
            lb1_q[pos_col_s] <= lb0_q[pos_col_s];
        end
    end

    // Counters, window columns and both pipeline stages; everything holds without advance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q       <= {CW{1'b0}};
            row_q       <= {RW{1'b0}};
            t0_q        <= {PIX_W{1'b0}};
            t1_q        <= {PIX_W{1'b0}};
            m0_q        <= {PIX_W{1'b0}};
            m1_q        <= {PIX_W{1'b0}};
            b0_q        <= {PIX_W{1'b0}};
            b1_q        <= {PIX_W{1'b0}};
            gx_q        <= {SW{1'b0}};
            gy_q        <= {SW{1'b0}};
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_edge_q  <= 1'b0;
        end else if (advance_s) begin
            col_q <= col_d;
            row_q <= row_d;
            if (accept_s) begin
                t0_q <= t1_q;
                t1_q <= top_s;
                m0_q <= m1_q;
                m1_q <= mid_s;
                b0_q <= b1_q;
                b1_q <= bot_s;
            end
            s1_valid_q <= produce_s;
            if (produce_s) begin
                gx_q <= gx_d;
                gy_q <= gy_d;
            end
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_edge_q <= (sum_s > thresh);
            end
        end
    end

`ifdef SOBEL_MAG_OUT_EN
    logic [PIX_W-1:0] out_mag_q;

    // Saturated magnitude registered alongside out_edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_mag_q <= {PIX_W{1'b0}};
        end else if (advance_s && s1_valid_q) begin
            out_mag_q <= (|sum_s[MW-1:PIX_W]) ? {PIX_W{1'b1}} : sum_s[PIX_W-1:0];
        end
    end

    assign out_mag = out_mag_q;
`endif

    assign in_ready  = advance_s;
    assign out_valid = out_valid_q;
    assign out_edge  = out_edge_q;

endmodule

// File: tb/tb_sobel_stream.sv
// Directed, table-driven bench for sobel_stream on a 5x5 image.
module tb_sobel_stream;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_pix = 8'd0;
    logic        in_sof = 1'b0;
    logic [11:0] thresh = 12'd128;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_edge;
`ifdef SOBEL_MAG_OUT_EN
    logic [7:0]  out_mag;
`endif

    int checks = 0;
    int errors = 0;
    logic       edge_q[$];
    logic [7:0] mag_q[$];

    sobel_stream #(.PIX_W(8), .IMG_W(5), .IMG_H(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_pix(in_pix), .in_sof(in_sof), .thresh(thresh),
        .out_valid(out_valid), .out_ready(out_ready), .out_edge(out_edge)
`ifdef SOBEL_MAG_OUT_EN
        , .out_mag(out_mag)
`endif
    );

    always #5 clk = ~clk;

    // Scoreboard capture: a result is consumed at the next rising edge.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            edge_q.push_back(out_edge);
`ifdef SOBEL_MAG_OUT_EN
            mag_q.push_back(out_mag);
`endif
        end
    end

    typedef struct {
        int          pat;
        logic [11:0] thr;
        logic [8:0]  edges;
        logic [71:0] mags;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [7:0] pix_f(input int pat, input int r, input int c);
        case (pat)
            1: return (c >= 2) ? 8'd255 : 8'd0;
            2: return 8'd100;
            3: return (c >= 2) ? 8'd32 : 8'd0;
            4: return (r >= 2) ? 8'd50 : 8'd0;
            5: return 8'(100 - 10 * c + 20 * r);
            default: return 8'd0;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] p, input logic sof);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_pix   = p;
        in_sof   = sof;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready %0d expected 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic check_results(input logic [8:0] edges, input logic [71:0] mags, input string name);
        chk({name, "_count"}, edge_q.size(), 9);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("%s_edge%0d", name, i), (i < edge_q.size()) ? int'(edge_q[i]) : -1, int'(edges[i]));
`ifdef SOBEL_MAG_OUT_EN
            chk($sformatf("%s_mag%0d", name, i), (i < mag_q.size()) ? int'(mag_q[i]) : -1, int'(mags[8*i +: 8]));
`endif
        end
    endtask

    task automatic run_frame(input int pat, input logic [11:0] thr, input logic [8:0] edges,
                             input logic [71:0] mags, input string name);
        thresh = thr;
        edge_q.delete();
        mag_q.delete();
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                send(pix_f(pat, r, c), (r == 0) && (c == 0));
        idle(4);
        check_results(edges, mags, name);
    endtask

    initial begin
        vecs[0] = '{0, 12'd128, 9'h000, 72'd0};
        vecs[1] = '{1, 12'd128, 9'h0DB, {3{8'd0, 8'd255, 8'd255}}};
        vecs[2] = '{2, 12'd0,   9'h000, 72'd0};
        vecs[3] = '{3, 12'd128, 9'h000, {3{8'd0, 8'd128, 8'd128}}};
        vecs[4] = '{3, 12'd127, 9'h0DB, {3{8'd0, 8'd128, 8'd128}}};
        vecs[5] = '{4, 12'd150, 9'h03F, {{3{8'd0}}, {6{8'd200}}}};
        vecs[6] = '{5, 12'd239, 9'h1FF, {9{8'd240}}};
        vecs[7] = '{5, 12'd240, 9'h000, {9{8'd240}}};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_edge", out_edge, 0);
        chk("reset_in_ready", in_ready, 1);
        rst = 1'b1;
        idle(2);

        for (int v = 0; v < 8; v++)
            run_frame(vecs[v].pat, vecs[v].thr, vecs[v].edges, vecs[v].mags, $sformatf("vec%0d", v));

        // Downstream stall mid-frame.
        thresh = 12'd150;
        edge_q.delete();
        mag_q.delete();
        fork
            begin
                for (int i = 0; i < 25; i++)
                    send(pix_f(4, i / 5, i % 5), i == 0);
            end
            begin
                int  n;
                logic held;
                repeat (20) @(posedge clk);
                #1;
                out_ready = 1'b0;
                n = 0;
                @(negedge clk);
                while (!out_valid && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                chk("stall_filled", out_valid, 1);
                held = out_edge;
                repeat (7) begin
                    @(negedge clk);
                    chk("stall_in_ready", in_ready, 0);
                    chk("stall_edge_stable", out_edge, held);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        idle(4);
        check_results(9'h03F, {{3{8'd0}}, {6{8'd200}}}, "stall");

        // Reset with a result in flight, then a frame without in_sof.
        thresh = 12'd128;
        edge_q.delete();
        mag_q.delete();
        for (int i = 0; i < 13; i++)
            send(pix_f(1, i / 5, i % 5), i == 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_edge", out_edge, 0);
        @(negedge clk);
        rst = 1'b1;
        idle(3);
        chk("rst_no_stale", edge_q.size(), 0);
        for (int i = 0; i < 25; i++) begin
            send(pix_f(1, i / 5, i % 5), 1'b0);
            if (i == 11) begin
                idle(3);
                chk("lat_none_before", edge_q.size(), 0);
            end
            if (i == 12) begin
                @(negedge clk);
                chk("lat_early", out_valid, 0);
                @(negedge clk);
                chk("lat_exact", out_valid, 1);
                @(posedge clk);
                #1;
            end
        end
        idle(4);
        check_results(9'h0DB, {3{8'd0, 8'd255, 8'd255}}, "rst_frame");

        // Start of frame in the middle of a line.
        edge_q.delete();
        for (int i = 0; i < 12; i++)
            send(pix_f(5, i / 5, i % 5), i == 0);
        idle(3);
        chk("sof_partial_none", edge_q.size(), 0);
        run_frame(1, 12'd128, 9'h0DB, {3{8'd0, 8'd255, 8'd255}}, "sof_mid");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
